// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed, word-wide memory with one-cycle read latency.
// Sub-word stores are done as read-modify-write because the memory always writes whole words.
module load_store_unit #(
  parameter int MEM_SIZE = 64000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_enable,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

  state_t      state, state_next;
  logic        r_write, r_signed;
  logic [1:0]  r_size, r_lane;
  logic [15:0] r_wdata;

  logic        accept, fault;
  logic [31:0] word_addr;
  logic [32:0] last_byte;
  logic [4:0]  shamt;
  logic [15:0] shifted;
  logic [31:0] load_data, lane_mask, lane_data, merged;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_enable = (state == RD) || (state == WR);
  assign mem_write  = (state == WR);
  assign accept     = req_valid && (state == IDLE);

  assign word_addr = {req_addr[31:2], 2'b00};
  // 33-bit sum so addresses near 2^32 cannot wrap past the limit check.
  assign last_byte = {1'b0, word_addr} + 33'd3;
  assign fault = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (last_byte >= MEM_LIMIT);

  assign shamt   = {r_lane, 3'b000};
  assign shifted = 16'(mem_rdata >> shamt);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    load_data = mem_rdata;
    case (r_size)
      2'b00:   load_data = {{24{r_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{r_signed & shifted[15]}}, shifted};
      default: load_data = mem_rdata;
    endcase
  end

  assign lane_mask = ((r_size == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
  assign lane_data = {16'h0000, r_wdata} << shamt;
  assign merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (fault)                               state_next = RESP;
        else if (req_write && req_size == 2'b10) state_next = WR;
        else                                     state_next = RD;
      end
      RD:      state_next = CAP;
      CAP:     state_next = r_write ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_write     <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_wdata     <= 16'h0000;
      mem_address <= 32'h0;
      mem_wdata   <= 32'h0;
      resp_rdata  <= 32'h0;
      resp_fault  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (accept) begin
        r_write  <= req_write;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_lane   <= req_addr[1:0];
        r_wdata  <= req_wdata[15:0];
        if (!fault) begin
          mem_address <= word_addr;
          mem_wdata   <= req_wdata;
        end
      end
      if (state == CAP && r_write) mem_wdata <= merged;
      // Response fields change only when a response is about to be presented.
      if (state_next == RESP) begin
        resp_fault <= (state == IDLE);
        resp_rdata <= (state == CAP && !r_write) ? load_data : 32'h0;
      end
    end
  end

endmodule
